lc3b_nway_cache: RTL and testbench

Parametrised N-way set-associative, write-back, write-allocate cache for the LC-3b memory hierarchy. It sits between the CPU data/instruction port (16-bit words) and physical memory (128-bit lines). It combines datapath and control in one block. It generalises the fixed 2-way design to WAYS ways and SETS sets, uses tree pseudo-LRU replacement, and adds saturating hit/miss counters.

---
 rtl/lc3b_nway_cache_pkg.sv | 32 +++
 rtl/lc3b_nway_cache_plru_tree.sv | 43 ++++
 rtl/lc3b_nway_cache.sv | 218 +++++++++++++++++++++
 tb/tb_lc3b_nway_cache.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_nway_cache_pkg.sv
// Shared types and helpers for the LC-3b N-way set-associative cache:
// line/word types, controller state encoding and word extract/merge.
package lc3b_nway_cache_pkg;

  localparam int LC3B_OFFSET_BITS    = 4;
  localparam int LC3B_WORDS_PER_LINE = 8;

  typedef logic [127:0] lc3b_line;
  typedef logic [15:0]  lc3b_word;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } lc3b_cache_state;

  // Extract the 16-bit word selected by address bits [3:1].
  function automatic lc3b_word word_select(input lc3b_line line, input logic [2:0] sel);
    return line[{sel, 4'b0000} +: 16];
  endfunction

  // Merge the enabled bytes of a CPU write into a line; be=00 returns the line untouched.
  function automatic lc3b_line word_insert(input lc3b_line line, input logic [2:0] sel,
                                           input logic [1:0] be, input lc3b_word wdata);
    lc3b_line merged;
    merged = line;
    if (be[0]) merged[{sel, 4'b0000} +: 8] = wdata[7:0];
    if (be[1]) merged[{sel, 4'b1000} +: 8] = wdata[15:8];
    return merged;
  endfunction

endpackage

// File: rtl/lc3b_nway_cache_plru_tree.sv
// Combinational tree pseudo-LRU for one set. Nodes are stored heap-style:
// node 0 is the root, children of node n are 2n+1 (left) and 2n+2 (right).
// A node bit of 0 means the victim lies in the left (lower-numbered) half.
module lc3b_nway_cache_plru_tree #(
  parameter int WAYS = 2
) (
  input  logic [WAYS-2:0]         i_bits,
  input  logic [$clog2(WAYS)-1:0] i_access,
  output logic [WAYS-2:0]         o_bits,
  output logic [$clog2(WAYS)-1:0] o_victim
);

  localparam int WAY_W = $clog2(WAYS);

  logic [WAY_W-1:0] w_vic;
  logic             w_node_bit;

  // Walk the tree from the root, following each node bit towards the victim.
  // NOTE: every variable gets a default before the loops; a path that leaves one unassigned would infer a latch.
  always_comb begin
    w_vic      = '0;
    w_node_bit = 1'b0;
    for (int l = 0; l < WAY_W; l++) begin
      w_node_bit = 1'b0;
      for (int p = 0; p < (1 << l); p++) begin
        if (int'(w_vic) == p) w_node_bit = i_bits[(1 << l) - 1 + p];
      end
      w_vic = (w_vic << 1) | WAY_W'(w_node_bit);
    end
    o_victim = w_vic;
  end

  // On the path to the accessed way, point every node at the opposite half.
  always_comb begin
    o_bits = i_bits;
    for (int l = 0; l < WAY_W; l++) begin
      for (int p = 0; p < (1 << l); p++) begin
        if (int'(i_access >> (WAY_W - l)) == p) o_bits[(1 << l) - 1 + p] = ~i_access[WAY_W - 1 - l];
      end
    end
  end

endmodule

// File: rtl/lc3b_nway_cache.sv
// N-way set-associative, write-back, write-allocate cache between the LC-3b
// CPU port (16-bit words) and physical memory (128-bit lines). Hits complete
// in the request cycle; misses optionally write back a dirty victim, fill the
// line, and let the held request retry as a hit.
module lc3b_nway_cache
  import lc3b_nway_cache_pkg::*;
#(
  parameter int WAYS  = 2,
  parameter int SETS  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [1:0]       mem_byte_enable,
  input  logic [15:0]      mem_address,
  input  logic [15:0]      mem_wdata,
  output logic [15:0]      mem_rdata,
  output logic             mem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic [15:0]      pmem_address,
  output logic [127:0]     pmem_wdata,
  input  logic [127:0]     pmem_rdata,
  input  logic             pmem_resp,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 16 - LC3B_OFFSET_BITS - IDX_W;
  localparam int WAY_W  = $clog2(WAYS);
  localparam int LADR_W = 16 - LC3B_OFFSET_BITS;

  // Array state
  logic [WAYS-1:0]  r_valid [SETS];
  logic [WAYS-1:0]  r_dirty [SETS];
  logic [WAYS-2:0]  r_plru  [SETS];
  logic [TAG_W-1:0] r_tag   [SETS][WAYS];
  lc3b_line         r_data  [SETS][WAYS];

  // Controller state
  lc3b_cache_state  r_state;
  logic             r_retry;
  logic [WAY_W-1:0] r_victim;
  logic [LADR_W-1:0] r_line_addr;
  logic             r_pmem_read;
  logic             r_pmem_write;
  logic [15:0]      r_pmem_address;
  lc3b_line         r_pmem_wdata;
  logic [CNT_W-1:0] r_hit_count;
  logic [CNT_W-1:0] r_miss_count;

  // Request decode
  logic [IDX_W-1:0] w_index;
  logic [TAG_W-1:0] w_tag;
  logic [2:0]       w_word;
  logic             w_req;
  logic             w_hit;
  logic [WAY_W-1:0] w_hit_way;
  logic             w_hit_req;
  logic             w_do_write;
  lc3b_line         w_hit_line;
  logic             w_any_invalid;
  logic [WAY_W-1:0] w_invalid_way;
  logic [WAY_W-1:0] w_plru_victim;
  logic [WAY_W-1:0] w_victim;
  logic             w_victim_dirty;
  logic [WAYS-2:0]  w_plru_next;
  logic [IDX_W-1:0] w_fill_index;
  logic [TAG_W-1:0] w_fill_tag;
  logic             w_unused;

  assign w_index  = mem_address[LC3B_OFFSET_BITS +: IDX_W];
  assign w_tag    = mem_address[15 -: TAG_W];
  assign w_word   = mem_address[3:1];
  assign w_unused = mem_address[0];

  // Requests are only serviced from IDLE and never while reset is asserted.
  assign w_req = !rst && (r_state == IDLE) && (mem_read || mem_write);

  // Tag compare across all valid ways of the indexed set.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (!w_hit && r_valid[w_index][i] && (r_tag[w_index][i] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(i);
      end
    end
  end

  // Lowest-numbered invalid way; scanning downwards lets the lowest index win.
  always_comb begin
    w_any_invalid = 1'b0;
    w_invalid_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!r_valid[w_index][i]) begin
        w_any_invalid = 1'b1;
        w_invalid_way = WAY_W'(i);
      end
    end
  end

  lc3b_nway_cache_plru_tree #(
    .WAYS(WAYS)
  ) u_plru (
    .i_bits  (r_plru[w_index]),
    .i_access(w_hit_way),
    .o_bits  (w_plru_next),
    .o_victim(w_plru_victim)
  );

  assign w_victim       = w_any_invalid ? w_invalid_way : w_plru_victim;
  assign w_victim_dirty = r_valid[w_index][w_victim] && r_dirty[w_index][w_victim];

  assign w_hit_req  = w_req && w_hit;
  assign w_do_write = w_hit_req && mem_write && (mem_byte_enable != 2'b00);
  assign w_hit_line = r_data[w_index][w_hit_way];

  // A simultaneous read and write is a write; rdata is only meaningful for reads.
  assign mem_resp  = w_hit_req;
  assign mem_rdata = w_hit_req ? word_select(w_hit_line, w_word) : 16'h0000;

  assign w_fill_index = r_line_addr[IDX_W-1:0];
  assign w_fill_tag   = r_line_addr[LADR_W-1 -: TAG_W];

  // Line and tag storage: byte merge on write hits, whole-line load on fill.
  // NOTE: data and tag arrays are deliberately not reset; the cleared valid bits make their contents irrelevant.
  always_ff @(posedge clk) begin
    if (w_do_write) begin
      r_data[w_index][w_hit_way] <= word_insert(w_hit_line, w_word, mem_byte_enable, mem_wdata);
    end else if (!rst && (r_state == FILL) && pmem_resp) begin
      r_data[w_fill_index][r_victim] <= pmem_rdata;
      r_tag[w_fill_index][r_victim]  <= w_fill_tag;
    end
  end

  // Controller FSM with registered memory-side outputs, status bits and counters.
  // NOTE: non-blocking assignments throughout so every update at this edge sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_retry        <= 1'b0;
      r_victim       <= '0;
      r_line_addr    <= '0;
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
      r_pmem_address <= '0;
      r_pmem_wdata   <= '0;
      r_hit_count    <= '0;
      r_miss_count   <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        r_plru[s]  <= '0;
      end
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_req && w_hit) begin
            r_plru[w_index] <= w_plru_next;
            if (w_do_write) r_dirty[w_index][w_hit_way] <= 1'b1;
            // The hit that completes a miss was already counted as that miss.
            if (r_retry) r_retry <= 1'b0;
            else if (r_hit_count != '1) r_hit_count <= r_hit_count + 1'b1;
          end else if (w_req) begin
            if (r_miss_count != '1) r_miss_count <= r_miss_count + 1'b1;
            r_victim    <= w_victim;
            r_line_addr <= mem_address[15:LC3B_OFFSET_BITS];
            if (w_victim_dirty) begin
              r_state        <= WRITEBACK;
              r_pmem_write   <= 1'b1;
              r_pmem_address <= {r_tag[w_index][w_victim], w_index, {LC3B_OFFSET_BITS{1'b0}}};
              r_pmem_wdata   <= r_data[w_index][w_victim];
            end else begin
              r_state        <= FILL;
              r_pmem_read    <= 1'b1;
              r_pmem_address <= {mem_address[15:LC3B_OFFSET_BITS], {LC3B_OFFSET_BITS{1'b0}}};
            end
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            r_state        <= FILL;
            r_pmem_write   <= 1'b0;
            r_pmem_read    <= 1'b1;
            r_pmem_address <= {r_line_addr, {LC3B_OFFSET_BITS{1'b0}}};
          end
        end
        FILL: begin
          if (pmem_resp) begin
            r_state                        <= IDLE;
            r_pmem_read                    <= 1'b0;
            r_retry                        <= 1'b1;
            r_valid[w_fill_index][r_victim] <= 1'b1;
            r_dirty[w_fill_index][r_victim] <= 1'b0;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_pmem_read  <= 1'b0;
          r_pmem_write <= 1'b0;
        end
      endcase
    end
  end

  assign pmem_read    = r_pmem_read;
  assign pmem_write   = r_pmem_write;
  assign pmem_address = r_pmem_address;
  assign pmem_wdata   = r_pmem_wdata;
  assign hit_count    = r_hit_count;
  assign miss_count   = r_miss_count;

endmodule

// File: tb/tb_lc3b_nway_cache.sv
// Self-checking bench for lc3b_nway_cache (WAYS=4, SETS=8): table-driven CPU
// accesses against a line-addressed memory model, plus hand-written sequences
// for cold miss, dirty eviction ordering, slow memory and reset mid-fill.
module tb_lc3b_nway_cache;

  logic         clk;
  logic         rst;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_address;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;

  lc3b_nway_cache #(
    .WAYS (4),
    .SETS (8),
    .CNT_W(16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_byte_enable(mem_byte_enable),
    .mem_address    (mem_address),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_resp       (mem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp_rdata;
    int          exp_miss;
  } vec_t;

  vec_t         vt[$];
  logic [127:0] mem_model [4096];

  int n_checks = 0;
  int n_fail   = 0;
  int lat      = 0;
  int cyc      = 0;
  int svc      = 0;
  int n_rd     = 0;
  int n_wr     = 0;
  int n_wait   = 0;
  int n_unstable    = 0;
  int n_resp_during = 0;
  int wr_stamp      = 0;
  int rd_stamp      = 0;
  int last_resp_cyc = 0;
  logic [15:0]  last_rd_addr = '0;
  logic [15:0]  last_wr_addr = '0;
  logic [127:0] last_wr_data = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever @(posedge clk) cyc++;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Physical memory responder: waits lat cycles per strobe, then answers for one cycle.
  initial begin : responder
    int          cnt;
    logic [15:0] hold;
    cnt        = 0;
    hold       = '0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pmem_resp = 1'b0;
        cnt       = 0;
      end else if (pmem_resp) begin
        pmem_resp = 1'b0;
        cnt       = 0;
      end else if (pmem_read || pmem_write) begin
        if (cnt == 0) hold = pmem_address;
        else if (pmem_address !== hold) n_unstable++;
        if (mem_resp) n_resp_during++;
        if (cnt >= lat) begin
          svc++;
          last_resp_cyc = cyc;
          if (pmem_write) begin
            mem_model[pmem_address[15:4]] = pmem_wdata;
            n_wr++;
            last_wr_addr = pmem_address;
            last_wr_data = pmem_wdata;
            wr_stamp     = svc;
          end else begin
            pmem_rdata   = mem_model[pmem_address[15:4]];
            n_rd++;
            last_rd_addr = pmem_address;
            rd_stamp     = svc;
          end
          pmem_resp = 1'b1;
        end else begin
          n_wait++;
        end
        cnt++;
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Present one CPU request, hold it until mem_resp, then drop it after the accepting edge.
  task automatic do_req(input logic wr, input logic [15:0] a, input logic [15:0] d,
                        input logic [1:0] be, output logic [15:0] rd, output int rcyc);
    bit done;
    done = 1'b0;
    rd   = '0;
    rcyc = -1;
    @(negedge clk);
    mem_read        = !wr;
    mem_write       = wr;
    mem_address     = a;
    mem_wdata       = d;
    mem_byte_enable = be;
    for (int k = 0; k < 200 && !done; k++) begin
      #1;
      if (mem_resp) begin
        rd   = mem_rdata;
        rcyc = cyc;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) check($sformatf("req_timeout_%0h", a), 128'(0), 128'(1));
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic run_vec(input int i);
    int          rd0;
    int          rc;
    logic [15:0] r;
    rd0 = n_rd;
    do_req(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].be, r, rc);
    if (!vt[i].wr) check($sformatf("vec%0d_rdata", i), 128'(r), 128'(vt[i].exp_rdata));
    check($sformatf("vec%0d_miss", i), 128'(n_rd - rd0), 128'(vt[i].exp_miss));
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) run_vec(i);
  endtask

  initial begin : main
    logic [15:0] r;
    int          rc;
    int          base;
    bit          seen;

    rst             = 1'b1;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = 2'b11;
    mem_address     = '0;
    mem_wdata       = '0;

    // Line L word w holds {L[7:0], 5'b0, w}; line 0x123 word 2 is 0xBEEF.
    for (int l = 0; l < 4096; l++) begin
      for (int w = 0; w < 8; w++) mem_model[l][w*16 +: 16] = {l[7:0], 5'd0, w[2:0]};
    end
    mem_model[12'h123][47:32] = 16'hBEEF;

    //            wr    addr      wdata     be     exp_rdata miss
    vt.push_back('{1'b1, 16'h1234, 16'hABCD, 2'b10, 16'h0000, 0});  // 0 byte merge (high byte)
    vt.push_back('{1'b0, 16'h1234, 16'h0000, 2'b11, 16'hABEF, 0});  // 1
    vt.push_back('{1'b0, 16'h0030, 16'h0000, 2'b11, 16'h0300, 1});  // 2 PLRU fill way 0
    vt.push_back('{1'b0, 16'h0130, 16'h0000, 2'b11, 16'h1300, 1});  // 3 way 1
    vt.push_back('{1'b0, 16'h0230, 16'h0000, 2'b11, 16'h2300, 1});  // 4 way 2
    vt.push_back('{1'b0, 16'h0330, 16'h0000, 2'b11, 16'h3300, 1});  // 5 way 3
    vt.push_back('{1'b0, 16'h0030, 16'h0000, 2'b11, 16'h0300, 0});  // 6 hit way 0
    vt.push_back('{1'b0, 16'h0430, 16'h0000, 2'b11, 16'h4300, 1});  // 7 evicts way 2
    vt.push_back('{1'b0, 16'h0230, 16'h0000, 2'b11, 16'h2300, 1});  // 8 was evicted
    vt.push_back('{1'b0, 16'h0030, 16'h0000, 2'b11, 16'h0300, 0});  // 9 still present
    vt.push_back('{1'b1, 16'h0030, 16'h1111, 2'b11, 16'h0000, 1});  // 10 write-allocate, dirty
    vt.push_back('{1'b0, 16'h0132, 16'h0000, 2'b11, 16'h1301, 1});  // 11 word 1
    vt.push_back('{1'b0, 16'h023E, 16'h0000, 2'b11, 16'h2307, 1});  // 12 word 7
    vt.push_back('{1'b0, 16'h0330, 16'h0000, 2'b11, 16'h3300, 1});  // 13
    vt.push_back('{1'b0, 16'h0430, 16'h0000, 2'b11, 16'h4300, 1});  // 14 evicts dirty way 0
    vt.push_back('{1'b0, 16'h0030, 16'h0000, 2'b11, 16'h1111, 1});  // 15 written-back data
    vt.push_back('{1'b0, 16'h0600, 16'h0000, 2'b11, 16'h6000, 1});  // 16 after reset mid-fill

    // Reset state
    do_reset();
    #1;
    check("rst_mem_resp", 128'(mem_resp), 128'(0));
    check("rst_pmem_read", 128'(pmem_read), 128'(0));
    check("rst_pmem_write", 128'(pmem_write), 128'(0));
    check("rst_mem_rdata", 128'(mem_rdata), 128'(0));
    check("rst_hit_count", 128'(hit_count), 128'(0));
    check("rst_miss_count", 128'(miss_count), 128'(0));

    // Cold read miss: fill from 0x1230, data one cycle after pmem_resp
    do_req(1'b0, 16'h1234, 16'h0000, 2'b11, r, rc);
    check("cold_rdata", 128'(r), 128'(16'hBEEF));
    check("cold_pmem_address", 128'(last_rd_addr), 128'(16'h1230));
    check("cold_resp_latency", 128'(rc), 128'(last_resp_cyc + 1));
    check("cold_pmem_reads", 128'(n_rd), 128'(1));
    check("cold_miss_count", 128'(miss_count), 128'(1));
    check("cold_hit_count", 128'(hit_count), 128'(0));

    // Byte write merge then read back, no memory traffic
    run_range(0, 1);
    check("merge_hit_count", 128'(hit_count), 128'(2));
    check("merge_miss_count", 128'(miss_count), 128'(1));
    check("merge_no_writeback", 128'(n_wr), 128'(0));

    // PLRU replacement in set 3
    do_reset();
    run_range(2, 9);
    check("plru_hit_count", 128'(hit_count), 128'(2));
    check("plru_miss_count", 128'(miss_count), 128'(6));

    // Dirty eviction: writeback of 0x0030 precedes the fill of 0x0430
    do_reset();
    run_range(10, 13);
    base = n_wr;
    run_vec(14);
    check("dirty_wb_count", 128'(n_wr - base), 128'(1));
    check("dirty_wb_address", 128'(last_wr_addr), 128'(16'h0030));
    check("dirty_wb_word0", 128'(last_wr_data[15:0]), 128'(16'h1111));
    check("dirty_wb_word1", 128'(last_wr_data[31:16]), 128'(16'h0301));
    check("dirty_wb_before_fill", 128'(wr_stamp < rd_stamp), 128'(1));
    check("dirty_fill_address", 128'(last_rd_addr), 128'(16'h0430));
    run_vec(15);

    // Slow memory: 10 wait cycles during FILL
    do_reset();
    lat  = 10;
    base = n_wait;
    n_unstable    = 0;
    n_resp_during = 0;
    do_req(1'b0, 16'h0500, 16'h0000, 2'b11, r, rc);
    check("slow_rdata", 128'(r), 128'(16'h5000));
    check("slow_wait_cycles", 128'(n_wait - base), 128'(10));
    check("slow_addr_stable", 128'(n_unstable), 128'(0));
    check("slow_no_early_resp", 128'(n_resp_during), 128'(0));
    check("slow_resp_latency", 128'(rc), 128'(last_resp_cyc + 1));

    // Reset pulsed during FILL abandons the transfer
    @(negedge clk);
    mem_read        = 1'b1;
    mem_write       = 1'b0;
    mem_address     = 16'h0600;
    mem_byte_enable = 2'b11;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      #1;
      if (pmem_read) seen = 1'b1;
      else @(negedge clk);
    end
    check("rstfill_started", 128'(seen), 128'(1));
    repeat (3) @(negedge clk);
    rst      = 1'b1;
    mem_read = 1'b0;
    @(posedge clk);
    #1;
    check("rstfill_pmem_read", 128'(pmem_read), 128'(0));
    check("rstfill_pmem_write", 128'(pmem_write), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    lat = 0;
    run_vec(16);
    check("rstfill_miss_count", 128'(miss_count), 128'(1));
    check("rstfill_hit_count", 128'(hit_count), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
